// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with glitch rejection and framing-error reporting
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_s;

  // Second synchronizer stage is the only view of the line the FSM ever uses.
  assign rx_s      = sync_q[1];
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

  // State, counters, synchronizer and output registers; sync flops reset to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      clk_cnt_q   <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: mid-bit sampling, LSB first; pulses default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = 16'd0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = 16'd0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d          = 16'd0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = 16'd0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            // Stop bit low: report once, then wait out any break condition.
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx
module tb_uart_rx;

  localparam int BIT_A = 16;
  localparam int BIT_B = 217;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_a [0:63];
  logic [7:0] got_b [0:63];
  int got_wr_a = 0, got_wr_b = 0;
  int rd_a = 0, rd_b = 0;
  int valid_cnt_a = 0, ferr_cnt_a = 0;
  int valid_cnt_b = 0, ferr_cnt_b = 0;
  logic prev_v_a = 1'b0, prev_f_a = 1'b0, prev_v_b = 1'b0, prev_f_b = 1'b0;
  logic excl_bad_a = 1'b0, dbl_bad_a = 1'b0, excl_bad_b = 1'b0, dbl_bad_b = 1'b0;

  uart_rx #(.CLKS_PER_BIT(BIT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .frame_err(frame_err_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(BIT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .frame_err(frame_err_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Capture every delivered byte and pulse-rule violations of instance A.
  always @(negedge clk) begin
    if (rx_valid_a) begin
      got_a[got_wr_a[5:0]] <= rx_data_a;
      got_wr_a    <= got_wr_a + 1;
      valid_cnt_a <= valid_cnt_a + 1;
    end
    if (frame_err_a) ferr_cnt_a <= ferr_cnt_a + 1;
    if (rx_valid_a && frame_err_a) excl_bad_a <= 1'b1;
    if ((rx_valid_a && prev_v_a) || (frame_err_a && prev_f_a)) dbl_bad_a <= 1'b1;
    prev_v_a <= rx_valid_a;
    prev_f_a <= frame_err_a;
  end

  // Same capture for instance B.
  always @(negedge clk) begin
    if (rx_valid_b) begin
      got_b[got_wr_b[5:0]] <= rx_data_b;
      got_wr_b    <= got_wr_b + 1;
      valid_cnt_b <= valid_cnt_b + 1;
    end
    if (frame_err_b) ferr_cnt_b <= ferr_cnt_b + 1;
    if (rx_valid_b && frame_err_b) excl_bad_b <= 1'b1;
    if ((rx_valid_b && prev_v_b) || (frame_err_b && prev_f_b)) dbl_bad_b <= 1'b1;
    prev_v_b <= rx_valid_b;
    prev_f_b <= frame_err_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send(input int which, input logic [7:0] b, input int bitc, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(which, fr[i]);
      repeat (bitc) @(posedge clk);
    end
  endtask

  // Pop the next delivered byte of one instance, bounded by max_cyc clocks.
  task automatic wait_byte(input int which, input int max_cyc, output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < max_cyc; i++) begin
      if (which == 0 && got_wr_a != rd_a) begin
        b = got_a[rd_a[5:0]]; rd_a++; ok = 1'b1; break;
      end
      if (which == 1 && got_wr_b != rd_b) begin
        b = got_b[rd_b[5:0]]; rd_b++; ok = 1'b1; break;
      end
      @(posedge clk);
    end
  endtask

  task automatic score(input int which, input string tag);
    logic [7:0] b, e;
    logic ok;
    wait_byte(which, 4000, b, ok);
    check({tag, "_arrived"}, ok, 1);
    e = exp_q.pop_front();
    if (ok) check({tag, "_data"}, b, e);
  endtask

  initial begin
    int v0, f0;
    logic [9:0] fr;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data_a, 8'h00);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_frame_err", frame_err_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    repeat (4 * BIT_A) @(posedge clk);

    // Single byte A5.
    v0 = valid_cnt_a; f0 = ferr_cnt_a;
    exp_q.push_back(8'hA5);
    send(0, 8'hA5, BIT_A, 1'b1);
    score(0, "a5");
    repeat (2 * BIT_A) @(posedge clk);
    check("a5_valid_count", valid_cnt_a - v0, 1);
    check("a5_ferr_count", ferr_cnt_a - f0, 0);
    check("a5_busy_after", busy_a, 0);

    // Zero-gap back-to-back frames.
    v0 = valid_cnt_a;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send(0, 8'h00, BIT_A, 1'b1);
    send(0, 8'hFF, BIT_A, 1'b1);
    send(0, 8'h3C, BIT_A, 1'b1);
    score(0, "b2b0");
    score(0, "b2b1");
    score(0, "b2b2");
    repeat (2 * BIT_A) @(posedge clk);
    check("b2b_valid_count", valid_cnt_a - v0, 3);

    // Short low glitch on idle line.
    v0 = valid_cnt_a; f0 = ferr_cnt_a;
    rx_a = 1'b0;
    repeat (5) @(posedge clk);
    rx_a = 1'b1;
    repeat (3 * BIT_A) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", busy_a, 0);
    check("glitch_valid_count", valid_cnt_a - v0, 0);
    check("glitch_ferr_count", ferr_cnt_a - f0, 0);
    check("glitch_rx_data", rx_data_a, 8'h3C);

    // Bad stop bit followed by a 40-bit break.
    v0 = valid_cnt_a; f0 = ferr_cnt_a;
    send(0, 8'h55, BIT_A, 1'b0);
    repeat (40 * BIT_A) @(posedge clk);
    @(negedge clk);
    check("break_busy_held", busy_a, 1);
    rx_a = 1'b1;
    repeat (2 * BIT_A) @(posedge clk);
    @(negedge clk);
    check("break_ferr_count", ferr_cnt_a - f0, 1);
    check("break_valid_count", valid_cnt_a - v0, 0);
    check("break_rx_data", rx_data_a, 8'h3C);
    check("break_busy_after", busy_a, 0);
    exp_q.push_back(8'h12);
    send(0, 8'h12, BIT_A, 1'b1);
    score(0, "post_break");
    repeat (2 * BIT_A) @(posedge clk);

    // Reset asserted at bit 4 of a frame.
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_a = fr[i];
      repeat (BIT_A) @(posedge clk);
    end
    rx_a = fr[5];
    @(negedge clk);
    check("midrst_busy_before", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", rx_data_a, 8'h00);
    check("midrst_rx_valid", rx_valid_a, 0);
    check("midrst_frame_err", frame_err_a, 0);
    check("midrst_busy", busy_a, 0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (BIT_A - 3) @(posedge clk);
    for (int i = 6; i < 10; i++) begin
      rx_a = fr[i];
      repeat (BIT_A) @(posedge clk);
    end
    repeat (12 * BIT_A) @(posedge clk);
    rd_a = got_wr_a;
    exp_q.push_back(8'hC3);
    send(0, 8'hC3, BIT_A, 1'b1);
    score(0, "post_reset");
    @(negedge clk);
    check("post_reset_rx_data", rx_data_a, 8'hC3);

    // 217 clocks per bit with the transmitter 2% slow then 2% fast.
    repeat (3 * BIT_B) @(posedge clk);
    exp_q.push_back(8'h96);
    send(1, 8'h96, 221, 1'b1);
    score(1, "skew_slow");
    repeat (3 * BIT_B) @(posedge clk);
    exp_q.push_back(8'h96);
    send(1, 8'h96, 213, 1'b1);
    score(1, "skew_fast");
    repeat (3 * BIT_B) @(posedge clk);
    check("skew_ferr_count", ferr_cnt_b, 0);
    check("skew_valid_count", valid_cnt_b, 2);

    check("pulse_exclusive_a", excl_bad_a, 0);
    check("pulse_single_a", dbl_bad_a, 0);
    check("pulse_exclusive_b", excl_bad_b, 0);
    check("pulse_single_b", dbl_bad_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the board-state transmitter.
- Carries host-to-FPGA traffic: AI move/command bytes from the PC back into the fabric.
- Runs in the 25 MHz VGA clock domain, fed directly from the asynchronous `rx` pin.
- Delivers each byte with a one-cycle valid strobe, plus framing-error reporting and glitch rejection.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per bit (25 MHz / 115200 baud); legal range 4..65535.

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  last correctly received byte, held until the next good byte
- rx_valid  out  1  one-cycle pulse: rx_data has just been updated
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset state (rst_n low, asynchronous):
  - state=IDLE, counters=0, shift register=0.
  - rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
  - Both synchronizer flops=1 (idle line).
- Input synchronization:
  - rx passes through a 2-flop synchronizer; rx_s is the second flop.
  - All decisions use rx_s only.
- Counters:
  - clk_cnt: 16-bit, counts 0..CLKS_PER_BIT-1.
  - bit_idx: 3-bit.
- IDLE:
  - rx_s==0 -> START, clk_cnt=0.
- START:
  - Increment clk_cnt until clk_cnt==(CLKS_PER_BIT-1)/2 (integer division); this is mid start bit.
  - At that cycle, rx_s==0 -> DATA, clk_cnt=0, bit_idx=0.
  - At that cycle, rx_s==1 -> IDLE: glitch rejected, no pulses.
- DATA:
  - When clk_cnt==CLKS_PER_BIT-1: sample rx_s into shift[bit_idx] (LSB first) and set clk_cnt=0.
  - bit_idx==7 at that sample -> STOP; otherwise bit_idx+1.
  - Other cycles: clk_cnt+1.
- STOP:
  - When clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: rx_data<=shift, rx_valid=1 for exactly one cycle, -> IDLE.
    - rx_s==0: rx_data unchanged, frame_err=1 for exactly one cycle, -> WAIT_HIGH.
- WAIT_HIGH (break recovery):
  - Stay until rx_s==1, then -> IDLE.
  - A line held low (break) yields exactly one frame_err and no spurious bytes.
- Latency:
  - rx_valid rises 2 (sync) + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the falling start edge at the pin, ±1 cycle of sampling phase.
- Back-to-back frames:
  - The stop-bit sample is mid-bit, so IDLE is re-entered about half a bit before the next start edge.
  - Zero-gap consecutive frames must all be received.
- Pulse exclusivity:
  - rx_valid and frame_err are never high in the same cycle.
  - Neither may be high on two consecutive cycles.
- Mid-frame reset:
  - rst_n asserted mid-frame aborts immediately with no pulse.
  - After release, the remainder of the aborted frame may be mis-framed.
  - The receiver must resynchronize on the first start bit following at least 10 bit-times of idle-high line.
- Counter width:
  - All counter comparisons are unsigned.
  - clk_cnt never exceeds CLKS_PER_BIT-1.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Reset, then drive byte 8'hA5 8N1 -> exactly one rx_valid pulse, rx_data==8'hA5, frame_err never high, busy low afterwards.
- Three back-to-back zero-gap frames 8'h00, 8'hFF, 8'h3C -> three rx_valid pulses, rx_data sequence 00, FF, 3C.
- 5-cycle low glitch on idle rx (shorter than half bit) -> return to IDLE, no rx_valid, no frame_err, rx_data unchanged.
- Byte 8'h55 with stop bit driven low and line then held low for 40 bit-times:
  - exactly one frame_err, no rx_valid, rx_data keeps its previous value;
  - after release high, next byte 8'h12 is received correctly.
- Assert rst_n low at bit 4 of a frame:
  - outputs go to reset values asynchronously;
  - after 10 idle bit-times, byte 8'hC3 is received correctly.
- CLKS_PER_BIT=217 at 25 MHz, transmitter baud skewed ±2% -> 8'h96 received correctly in both skew directions.
